// File: rtl/hilo_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hilo_md_ctrl
// Description : EX-stage multiply/divide sequencer. Accepts one mult/multu/
//               div/divu at a time, drives the pipelined multiplier and the
//               iterative divider, stalls EX until the result is ready,
//               honours flush, and issues the HI/LO write. mthi/mtlo are
//               written straight through from IDLE without stalling.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_md_ctrl #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        stallreq,
    output logic        busy,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_annul,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MUL_WAIT = 2'd1;
    localparam logic [1:0] S_DIV_WAIT = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       op_q,    op_d;
    logic [31:0]      src1_q,  src1_d;
    logic [31:0]      src2_q,  src2_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;

    logic is_mul_op;
    logic is_div_op;
    logic accept;

    assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
    // Only IDLE accepts, and a flush in the same cycle cancels the acceptance.
    assign accept    = (state_q == S_IDLE) && op_valid && !flush &&
                       (is_mul_op || is_div_op);

    // State register: FSM state, latency counter, latched operands, results.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            src1_q  <= 32'd0;
            src2_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state logic: flush beats acceptance, div_ready and counter expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_d   = op;
                        src1_d = src1;
                        src2_d = src2;
                        if (is_mul_op) begin
                            state_d = S_MUL_WAIT;
                            cnt_d   = CNT_W'(MUL_LATENCY);
                        end else if (src2 != 32'd0) begin
                            state_d = S_DIV_WAIT;
                        end else begin
                            // Divide by zero: architected result without
                            // ever starting the divider.
                            state_d = S_DONE;
                            hi_d    = src1;
                            lo_d    = 32'hFFFF_FFFF;
                        end
                    end
                end
                S_MUL_WAIT: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        hi_d    = mul_result[63:32];
                        lo_d    = mul_result[31:0];
                        state_d = S_DONE;
                    end
                end
                S_DIV_WAIT: begin
                    if (div_ready) begin
                        hi_d    = div_result[63:32];
                        lo_d    = div_result[31:0];
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output logic: resource operands only in their wait state, HI/LO write
    // in DONE or from an IDLE mthi/mtlo; IDLE-path outputs forced low in reset.
    always_comb begin
        stallreq    = 1'b0;
        busy        = (state_q != S_IDLE);
        mul_signed  = 1'b0;
        mul_ina     = 32'd0;
        mul_inb     = 32'd0;
        div_start   = 1'b0;
        div_annul   = 1'b0;
        div_signed  = 1'b0;
        div_opdata1 = 32'd0;
        div_opdata2 = 32'd0;
        hi_we       = 1'b0;
        lo_we       = 1'b0;
        hi_wdata    = 32'd0;
        lo_wdata    = 32'd0;
        case (state_q)
            S_IDLE: begin
                stallreq = accept && resetn;
                if (resetn && op_valid && !flush && (op == OP_MTHI)) begin
                    hi_we    = 1'b1;
                    hi_wdata = src1;
                end
                if (resetn && op_valid && !flush && (op == OP_MTLO)) begin
                    lo_we    = 1'b1;
                    lo_wdata = src1;
                end
            end
            S_MUL_WAIT: begin
                stallreq   = 1'b1;
                mul_signed = (op_q == OP_MULT);
                mul_ina    = src1_q;
                mul_inb    = src2_q;
            end
            S_DIV_WAIT: begin
                stallreq    = 1'b1;
                div_start   = !flush;
                div_annul   = flush;
                div_signed  = (op_q == OP_DIV);
                div_opdata1 = src1_q;
                div_opdata2 = src2_q;
            end
            default: begin
                if (!flush) begin
                    hi_we    = 1'b1;
                    lo_we    = 1'b1;
                    hi_wdata = hi_q;
                    lo_wdata = lo_q;
                end
            end
        endcase
    end

endmodule
`default_nettype wire
